// File: rtl/sdram_bus_pkg.sv
// ---------------------------------------------------------------------------
// sdram_bus_pkg
// Shared definitions for the SDRAM bus arbiter: the arbiter state encoding,
// default bus widths and the bank/row/column field positions within a bus
// address.
// ---------------------------------------------------------------------------
package sdram_bus_pkg;

   typedef enum logic [1:0] {
      HOLDOFF = 2'd0,   // waiting for controller power-up sequence
      IDLE    = 2'd1,   // ready to grant
      WAIT    = 2'd2,   // request outstanding at the controller
      GAP     = 2'd3    // forced request-low cycle between transactions
   } state_t;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;

   // Bus address layout {bank, row, col}
   localparam int BANK_MSB = 24;
   localparam int BANK_LSB = 23;
   localparam int ROW_MSB  = 22;
   localparam int ROW_LSB  = 10;
   localparam int COL_MSB  = 9;
   localparam int COL_LSB  = 0;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request bit at or after the
// pointer, wrapping modulo N.
//   i_req      : request vector
//   i_ptr      : highest-priority index this round
//   o_gnt      : one-hot grant
//   o_gnt_idx  : index of the granted bit
//   o_any_gnt  : at least one request was set
// ---------------------------------------------------------------------------
module rr_arbiter
   import sdram_bus_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_any_gnt
);

   // One extra bit so ptr+k never overflows before the modulo fold
   logic [IW:0] w_pos;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any_gnt = 1'b0;
      w_pos     = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_pos >= (IW+1)'(N))
            w_pos = w_pos - (IW+1)'(N);
         if (!o_any_gnt && i_req[w_pos[IW-1:0]]) begin
            o_any_gnt              = 1'b1;
            o_gnt_idx              = w_pos[IW-1:0];
            o_gnt[w_pos[IW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_bus_arbiter
// Shares one SDRAM controller bus between N_REQ requesters (round-robin).
// Holds off all grants until the controller power-up time has elapsed, turns
// valid/ready requests into the controller's rising-edge request protocol and
// returns read data or a timeout error to the owning requester.
//   clock, reset                 : clock, synchronous active-high reset
//   req_valid/write/address/...  : packed per-requester request inputs
//   req_ready                    : one-cycle accept pulse (one-hot)
//   rsp_valid/error/read_data    : one-cycle completion pulse (one-hot)
//   mem_*                        : controller-side request/response
//   init_done                    : power-up holdoff has elapsed
//   busy                         : arbiter is not idle
// ---------------------------------------------------------------------------
module sdram_bus_arbiter #(
   parameter int N_REQ               = 4,
   parameter int ADDR_W              = 25,
   parameter int DATA_W              = 32,
   parameter int INIT_HOLDOFF_CYCLES = 26000,
   parameter int TIMEOUT_CYCLES      = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_address,
   input  logic [N_REQ*DATA_W-1:0] req_write_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic                    rsp_error,
   output logic [DATA_W-1:0]       rsp_read_data,
   output logic                    mem_request,
   output logic                    mem_write_enable,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [DATA_W-1:0]       mem_write_data,
   input  logic                    mem_response,
   input  logic [DATA_W-1:0]       mem_read_data,
   output logic                    init_done,
   output logic                    busy
);
   import sdram_bus_pkg::*;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = $clog2(INIT_HOLDOFF_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t          r_state;
   logic [HW-1:0]   r_hold_cnt;
   logic [TW-1:0]   r_to_cnt;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;

   logic [N_REQ-1:0] w_gnt;
   logic [IW-1:0]    w_idx;
   logic             w_any;

   logic [ADDR_W-1:0] w_addr  [N_REQ];
   logic [DATA_W-1:0] w_wdata [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_addr[g]  = req_address[g*ADDR_W +: ADDR_W];
      assign w_wdata[g] = req_write_data[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(.N(N_REQ)) u_rr (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_idx),
      .o_any_gnt (w_any)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= HOLDOFF;
         r_hold_cnt       <= '0;
         r_to_cnt         <= '0;
         r_ptr            <= '0;
         r_owner          <= '0;
         req_ready        <= '0;
         rsp_valid        <= '0;
         rsp_error        <= 1'b0;
         rsp_read_data    <= '0;
         mem_request      <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_address      <= '0;
         mem_write_data   <= '0;
         init_done        <= 1'b0;
         busy             <= 1'b0;
      end else begin
         // Accept and completion strobes are single-cycle
         req_ready <= '0;
         rsp_valid <= '0;
         case (r_state)
            HOLDOFF: begin
               if (r_hold_cnt == HW'(INIT_HOLDOFF_CYCLES - 1)) begin
                  r_state   <= IDLE;
                  init_done <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                  busy       <= 1'b1;
               end
            end
            IDLE: begin
               if (w_any) begin
                  req_ready        <= w_gnt;
                  r_owner          <= w_idx;
                  mem_address      <= w_addr[w_idx];
                  mem_write_data   <= w_wdata[w_idx];
                  // Request and write_enable rise together: the controller
                  // only samples write_enable on the request rising edge.
                  mem_request      <= 1'b1;
                  mem_write_enable <= req_write[w_idx];
                  r_ptr            <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                  r_to_cnt         <= '0;
                  r_state          <= WAIT;
                  busy             <= 1'b1;
               end
            end
            WAIT: begin
               // A response in the timeout cycle still counts as success
               if (mem_response) begin
                  rsp_valid        <= N_REQ'(1) << r_owner;
                  rsp_error        <= 1'b0;
                  rsp_read_data    <= mem_read_data;
                  mem_request      <= 1'b0;
                  mem_write_enable <= 1'b0;
                  r_state          <= GAP;
               end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid        <= N_REQ'(1) << r_owner;
                  rsp_error        <= 1'b1;
                  rsp_read_data    <= '0;
                  mem_request      <= 1'b0;
                  mem_write_enable <= 1'b0;
                  r_state          <= GAP;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            GAP: begin
               // Guarantees the controller sees a fresh rising edge next time
               r_state <= IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= HOLDOFF;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_bus_arbiter;

   localparam int N    = 4;
   localparam int AW   = 25;
   localparam int DW   = 32;
   localparam int HOLD = 20;
   localparam int TOUT = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_write = '0;
   logic [N*AW-1:0] req_address = '0;
   logic [N*DW-1:0] req_write_data = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic            rsp_error;
   logic [DW-1:0]   rsp_read_data;
   logic            mem_request;
   logic            mem_write_enable;
   logic [AW-1:0]   mem_address;
   logic [DW-1:0]   mem_write_data;
   logic            mem_response = 1'b0;
   logic [DW-1:0]   mem_read_data = '0;
   logic            init_done;
   logic            busy;

   sdram_bus_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW),
      .INIT_HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_address(req_address), .req_write_data(req_write_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
      .rsp_read_data(rsp_read_data), .mem_request(mem_request),
      .mem_write_enable(mem_write_enable), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_response(mem_response),
      .mem_read_data(mem_read_data), .init_done(init_done), .busy(busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { int idx; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gnt_t;
   typedef struct { int idx; bit err; bit chk; logic [DW-1:0] data; } rsp_t;
   gnt_t gnt_q[$];
   rsp_t rsp_q[$];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {7'h55, a} ^ 32'h1234_5678;
   endfunction

   // Controller model: responds m_lat cycles after the request rising edge
   // (0 = never). Writes are stored; unwritten reads return pat(addr).
   int            m_lat = 2;
   int            m_cnt = 0;
   bit            m_done = 0;
   int            spur_req = 0;
   int            spur_done = 0;
   logic [DW-1:0] mem_model [logic [AW-1:0]];

   always @(negedge clock) begin
      mem_response = 1'b0;
      if (!mem_request) begin
         m_cnt  = 0;
         m_done = 0;
      end else if (!m_done) begin
         m_cnt++;
         if (m_lat != 0 && m_cnt == m_lat) begin
            mem_response = 1'b1;
            m_done       = 1;
            if (mem_write_enable) begin
               mem_model[mem_address] = mem_write_data;
               mem_read_data = 32'h0BAD_F00D;
            end else begin
               mem_read_data = mem_model.exists(mem_address) ? mem_model[mem_address]
                                                             : pat(mem_address);
            end
         end
      end
      if (spur_req != spur_done) begin
         mem_response  = 1'b1;
         mem_read_data = 32'hFFFF_FFFF;
         spur_done     = spur_req;
      end
   end

   // Scoreboard monitor: grants and completions against queued expectations
   gnt_t mg;
   rsp_t mr;
   bit   prev_req = 0;
   int   rsp_cnt = 0;

   always @(negedge clock) begin
      if (req_ready != '0) begin
         checks++;
         if ((req_ready & rsp_valid) != '0) begin
            failures++;
            $display("FAIL ready_rsp_overlap req_ready=%b rsp_valid=%b required disjoint", req_ready, rsp_valid);
         end
         checks++;
         if (gnt_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant req_ready=%b required none", req_ready);
         end else begin
            mg = gnt_q.pop_front();
            if (req_ready !== (N'(1) << mg.idx) || mem_request !== 1'b1 ||
                mem_write_enable !== mg.wr || mem_address !== mg.addr ||
                (mg.wr && mem_write_data !== mg.wdata) || prev_req !== 1'b0) begin
               failures++;
               $display("FAIL grant req_ready=%b we=%b addr=%h wd=%h prev_req=%b required idx=%0d we=%b addr=%h wd=%h prev_req=0",
                        req_ready, mem_write_enable, mem_address, mem_write_data, prev_req,
                        mg.idx, mg.wr, mg.addr, mg.wdata);
            end
         end
      end
      if (rsp_valid != '0) begin
         rsp_cnt++;
         checks++;
         if (rsp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp rsp_valid=%b required none", rsp_valid);
         end else begin
            mr = rsp_q.pop_front();
            if (rsp_valid !== (N'(1) << mr.idx) || rsp_error !== mr.err ||
                (mr.chk && rsp_read_data !== mr.data)) begin
               failures++;
               $display("FAIL rsp rsp_valid=%b err=%b data=%h required idx=%0d err=%b data=%h",
                        rsp_valid, rsp_error, rsp_read_data, mr.idx, mr.err, mr.data);
            end
         end
      end
      prev_req = mem_request;
   end

   // Stimulus helpers (no comparisons; callers judge the ok flags)
   task automatic issue(input int r, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit err, input bit chk,
                        input logic [DW-1:0] exp_d, output bit ok, output int tg);
      gnt_q.push_back('{r, wr, a, d});
      rsp_q.push_back('{r, err, chk, exp_d});
      req_write[r] = wr;
      req_address[r*AW +: AW] = a;
      req_write_data[r*DW +: DW] = d;
      req_valid[r] = 1'b1;
      ok = 0;
      tg = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (req_ready[r]) begin ok = 1; tg = cyc; break; end
      end
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_rsp(output int t, output bit ok, output bit we_seen);
      ok = 0; t = 0; we_seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (mem_write_enable) we_seen = 1;
         if (rsp_valid != '0) begin ok = 1; t = cyc; break; end
      end
   endtask

   task automatic drain(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (gnt_q.size() == 0 && rsp_q.size() == 0) begin ok = 1; break; end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '0;
      repeat (3) @(negedge clock);
      checks++;
      if ({req_ready, rsp_valid, rsp_error, mem_request, mem_write_enable, init_done, busy} !== '0 ||
          rsp_read_data !== '0 || mem_address !== '0 || mem_write_data !== '0) begin
         failures++;
         $display("FAIL reset_outputs ready=%b rsp=%b req=%b init=%b busy=%b addr=%h required all 0",
                  req_ready, rsp_valid, mem_request, init_done, busy, mem_address);
      end
   endtask

   task automatic test_holdoff();
      bit bad = 0;
      bit ok;
      m_lat = 3;
      req_write[0] = 1'b1;
      req_address[0 +: AW] = 25'h1A2B3C4;
      req_write_data[0 +: DW] = 32'hCAFE_0001;
      gnt_q.push_back('{0, 1'b1, 25'h1A2B3C4, 32'hCAFE_0001});
      rsp_q.push_back('{0, 1'b0, 1'b0, 32'h0});
      req_valid = 4'b0001;
      reset = 1'b0;
      for (int k = 1; k < HOLD; k++) begin
         @(negedge clock);
         if (req_ready !== '0 || init_done !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL holdoff_quiet saw ready or init_done during holdoff, required 0"); end
      @(negedge clock);
      checks++;
      if (init_done !== 1'b1 || req_ready !== '0) begin
         failures++;
         $display("FAIL init_done_rise init=%b ready=%b required 1 and 0000", init_done, req_ready);
      end
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0001 || mem_request !== 1'b1 || mem_write_enable !== 1'b1) begin
         failures++;
         $display("FAIL first_grant ready=%b req=%b we=%b required 0001 1 1", req_ready, mem_request, mem_write_enable);
      end
      req_valid = '0;
      drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL holdoff_drain pending=%0d required 0", rsp_q.size()); end
   endtask

   task automatic test_write_read();
      bit ok, ok2, we;
      int tg, tr;
      m_lat = 6;
      issue(1, 1'b1, 25'h0123456, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, ok, tg);
      wait_rsp(tr, ok2, we);
      checks++;
      if (!ok || !ok2 || tr - tg != 6 || rsp_valid !== 4'b0010 || rsp_error !== 1'b0) begin
         failures++;
         $display("FAIL write_rsp latency=%0d rsp=%b err=%b required 6 0010 0", tr - tg, rsp_valid, rsp_error);
      end
      drain(ok);
      issue(1, 1'b0, 25'h0123456, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, ok, tg);
      wait_rsp(tr, ok2, we);
      checks++;
      if (!ok || !ok2 || we || rsp_read_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL read_back data=%h we_seen=%b required deadbeef 0", rsp_read_data, we);
      end
      drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL write_read_drain pending=%0d required 0", rsp_q.size()); end
   endtask

   task automatic test_timeout();
      bit ok, ok2, we;
      int tg, tr;
      m_lat = 0;
      issue(2, 1'b0, 25'h0800100, 32'h0, 1'b1, 1'b1, 32'h0, ok, tg);
      wait_rsp(tr, ok2, we);
      checks++;
      if (!ok || !ok2 || tr - tg != TOUT || rsp_error !== 1'b1 || rsp_valid !== 4'b0100) begin
         failures++;
         $display("FAIL timeout latency=%0d err=%b rsp=%b required %0d 1 0100", tr - tg, rsp_error, rsp_valid, TOUT);
      end
      drain(ok);
      m_lat = 2;
      issue(3, 1'b1, 25'h1FFFFFF, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, ok, tg);
      wait_rsp(tr, ok2, we);
      checks++;
      if (!ok || !ok2 || rsp_error !== 1'b0 || rsp_valid !== 4'b1000 || tr - tg != 2) begin
         failures++;
         $display("FAIL after_timeout err=%b rsp=%b latency=%0d required 0 1000 2", rsp_error, rsp_valid, tr - tg);
      end
      drain(ok);
   endtask

   task automatic test_simultaneous();
      bit ok, ok2, we;
      int tg, tr, c;
      m_lat = TOUT;
      issue(0, 1'b0, 25'h0400040, 32'h0, 1'b0, 1'b1, pat(25'h0400040), ok, tg);
      wait_rsp(tr, ok2, we);
      checks++;
      if (!ok || !ok2 || tr - tg != TOUT || rsp_error !== 1'b0 || rsp_read_data !== pat(25'h0400040)) begin
         failures++;
         $display("FAIL rsp_vs_timeout latency=%0d err=%b data=%h required %0d 0 %h",
                  tr - tg, rsp_error, rsp_read_data, TOUT, pat(25'h0400040));
      end
      drain(ok);
      repeat (3) @(negedge clock);
      c = rsp_cnt;
      spur_req++;
      repeat (6) @(negedge clock);
      checks++;
      if (rsp_cnt != c || mem_request !== 1'b0) begin
         failures++;
         $display("FAIL spurious_response rsp_pulses=%0d req=%b required 0 0", rsp_cnt - c, mem_request);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok, wentlive;
      int tg, c0, t;
      m_lat = 0;
      issue(1, 1'b0, 25'h0000777, 32'h0, 1'b0, 1'b0, 32'h0, ok, tg);
      repeat (5) @(negedge clock);
      checks++;
      if (!ok || mem_request !== 1'b1) begin
         failures++;
         $display("FAIL mid_wait_setup req=%b required 1", mem_request);
      end
      rsp_q.delete();
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({req_ready, rsp_valid, rsp_error, mem_request, mem_write_enable, init_done, busy} !== '0 ||
          mem_address !== '0 || rsp_read_data !== '0) begin
         failures++;
         $display("FAIL reset_mid_wait ready=%b rsp=%b req=%b init=%b busy=%b required all 0",
                  req_ready, rsp_valid, mem_request, init_done, busy);
      end
      reset = 1'b0;
      c0 = cyc;
      wentlive = 0;
      t = 0;
      for (int i = 0; i < 4 * HOLD; i++) begin
         @(negedge clock);
         if (init_done) begin wentlive = 1; t = cyc; break; end
      end
      checks++;
      if (!wentlive || t - c0 != HOLD) begin
         failures++;
         $display("FAIL holdoff_restart init_after=%0d required %0d", t - c0, HOLD);
      end
   endtask

   task automatic test_round_robin();
      int got = 0;
      bit ok;
      logic [AW-1:0] a;
      m_lat = 2;
      for (int i = 0; i < N; i++) begin
         req_write[i] = 1'b0;
         req_address[i*AW +: AW] = AW'(32'h0100000 * i + 32'h20);
      end
      for (int k = 0; k < 5; k++) begin
         a = AW'(32'h0100000 * (k % N) + 32'h20);
         gnt_q.push_back('{k % N, 1'b0, a, 32'h0});
         rsp_q.push_back('{k % N, 1'b0, 1'b1, pat(a)});
      end
      req_valid = '1;
      for (int i = 0; i < 400 && got < 5; i++) begin
         @(negedge clock);
         if (req_ready != '0) got++;
      end
      req_valid = '0;
      checks++;
      if (got != 5) begin failures++; $display("FAIL rr_grant_count got=%0d required 5", got); end
      drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_drain pending=%0d required 0", rsp_q.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_holdoff();
      test_write_read();
      test_timeout();
      test_simultaneous();
      test_reset_mid_wait();
      test_round_robin();
      repeat (5) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
